// File: rtl/win_screen_overlay_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : win_screen_overlay_pkg
//  Brief    : Display constants and overlay FSM encoding for the win overlay.
//  Revision : 1.0
// ============================================================================
package win_screen_overlay_pkg;

    localparam int c_h_active = 640;
    localparam int c_v_active = 480;
    localparam int c_img_size = 256;
    localparam int c_rgb_w    = 12;
    localparam int c_addr_w   = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SHOW = 1'b1
    } ovl_state_t;

endpackage
`default_nettype wire

// File: rtl/win_blink_timer.sv
`default_nettype none
// ============================================================================
//  Module   : win_blink_timer
//  Brief    : Frame counter producing the visible/hidden blink phase.
//  Revision : 1.0
// ============================================================================
module win_blink_timer #(
    parameter int BLINK_FRAMES = 30
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic frame_start,
    output logic visible
);

    localparam int c_cnt_w = $clog2(BLINK_FRAMES) + 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(BLINK_FRAMES - 1);

    logic [c_cnt_w-1:0] r_count;
    logic               r_visible;

    // Clear wins over frame_start so re-entry always starts a visible half-period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count   <= '0;
            r_visible <= 1'b1;
        end else if (clear) begin
            r_count   <= '0;
            r_visible <= 1'b1;
        end else if (frame_start) begin
            if (r_count == c_last) begin
                r_count   <= '0;
                r_visible <= ~r_visible;
            end else begin
                r_count <= r_count + c_cnt_w'(1);
            end
        end
    end

    assign visible = r_visible;

endmodule
`default_nettype wire

// File: rtl/win_screen_overlay.sv
`default_nettype none
// ============================================================================
//  Module   : win_screen_overlay
//  Brief    : Addresses the win-image ROM and composites it, blinking and
//             centred, over the game pixel stream while the game is won.
//  Revision : 1.0
// ============================================================================
module win_screen_overlay
    import win_screen_overlay_pkg::*;
#(
    parameter int                  IMG_X0       = (c_h_active - c_img_size) / 2,
    parameter int                  IMG_Y0       = (c_v_active - c_img_size) / 2,
    parameter int                  BLINK_FRAMES = 30,
    parameter logic [c_rgb_w-1:0]  BG_RGB       = 12'h000,
    parameter logic [c_rgb_w-1:0]  KEY_RGB      = 12'hF0F
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [9:0]          pix_x,
    input  logic [9:0]          pix_y,
    input  logic                video_on,
    input  logic                frame_start,
    input  logic                game_win,
    input  logic [c_rgb_w-1:0]  game_rgb,
    output logic [c_addr_w-1:0] rom_addr,
    input  logic [c_rgb_w-1:0]  rom_data,
    output logic [c_rgb_w-1:0]  rgb_out,
    output logic                overlay_active
);

    localparam logic [9:0] c_img_x0  = 10'(IMG_X0);
    localparam logic [9:0] c_img_y0  = 10'(IMG_Y0);
    localparam logic [9:0] c_img_lim = 10'(c_img_size);

    logic [9:0]         w_dx;
    logic [9:0]         w_dy;
    logic               w_in_win;
    logic               w_visible;
    logic               w_blink_clear;
    logic               w_blink_tick;
    logic [c_rgb_w-1:0] w_rgb_next;
    ovl_state_t         r_state;
    ovl_state_t         w_state_next;

    logic               r_in_win_d;
    logic               r_video_on_d;
    logic [c_rgb_w-1:0] r_game_rgb_d;
    logic [c_rgb_w-1:0] r_rgb_out;
    logic               r_overlay_active;

    // Unsigned wrap makes coordinates left of / above the window fail the test.
    assign w_dx     = pix_x - c_img_x0;
    assign w_dy     = pix_y - c_img_y0;
    assign w_in_win = (w_dx < c_img_lim) && (w_dy < c_img_lim);
    assign rom_addr = w_in_win ? {w_dy[7:0], w_dx[7:0]} : '0;

    win_blink_timer #(
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_blink (
        .clk         (clk),
        .rst         (rst),
        .clear       (w_blink_clear),
        .frame_start (w_blink_tick),
        .visible     (w_visible)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= IDLE;
            r_overlay_active <= 1'b0;
        end else begin
            r_state          <= w_state_next;
            r_overlay_active <= (w_state_next == SHOW);
        end
    end

    // State changes only on frame_start so the picture never tears mid-frame.
    always_comb begin
        w_state_next  = r_state;
        w_blink_clear = (r_state == IDLE);
        w_blink_tick  = 1'b0;
        case (r_state)
            IDLE: if (frame_start && game_win) w_state_next = SHOW;
            SHOW: begin
                if (frame_start && !game_win) w_state_next = IDLE;
                w_blink_tick = frame_start && game_win;
            end
            default: w_state_next = IDLE;
        endcase

        w_rgb_next = BG_RGB;
        if (!r_video_on_d)                              w_rgb_next = '0;
        else if (r_state == IDLE)                       w_rgb_next = r_game_rgb_d;
        else if (!w_visible)                            w_rgb_next = BG_RGB;
        else if (r_in_win_d && (rom_data != KEY_RGB))   w_rgb_next = rom_data;
    end

    // Stage 1 aligns pixel side-band with the ROM's one-cycle read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_win_d   <= 1'b0;
            r_video_on_d <= 1'b0;
            r_game_rgb_d <= '0;
            r_rgb_out    <= '0;
        end else begin
            r_in_win_d   <= w_in_win;
            r_video_on_d <= video_on;
            r_game_rgb_d <= game_rgb;
            r_rgb_out    <= w_rgb_next;
        end
    end

    assign rgb_out        = r_rgb_out;
    assign overlay_active = r_overlay_active;

endmodule
`default_nettype wire

// File: tb/tb_win_screen_overlay.sv
`default_nettype none
// ============================================================================
//  Module   : tb_win_screen_overlay
//  Brief    : Directed and randomized checks of the win overlay against a
//             frame-counting reference model.
//  Revision : 1.0
// ============================================================================
module tb_win_screen_overlay;

    localparam logic [11:0] c_bg  = 12'h05A;
    localparam logic [11:0] c_key = 12'hF0F;
    localparam int          c_bf  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  pix_x, pix_y;
    logic        video_on, frame_start, game_win;
    logic [11:0] game_rgb;
    logic [15:0] rom_addr;
    logic [11:0] rom_data = '0;
    logic [11:0] rgb_out;
    logic        overlay_active;

    logic [11:0] rom [0:65535];

    int total = 0;
    int bad   = 0;

    // Reference model: overlay shown flag, frames counted since entry.
    bit          m_show;
    int          m_n;
    logic [11:0] m_prev;
    logic [15:0] obs_addr, exp_addr;
    logic [11:0] exp_rgb;
    bit          exp_ov;

    win_screen_overlay #(
        .IMG_X0       (192),
        .IMG_Y0       (112),
        .BLINK_FRAMES (c_bf),
        .BG_RGB       (c_bg),
        .KEY_RGB      (c_key)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pix_x          (pix_x),
        .pix_y          (pix_y),
        .video_on       (video_on),
        .frame_start    (frame_start),
        .game_win       (game_win),
        .game_rgb       (game_rgb),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .rgb_out        (rgb_out),
        .overlay_active (overlay_active)
    );

    always #5 clk = ~clk;
    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic model_reset();
        m_show = 1'b0;
        m_n    = 0;
        m_prev = '0;
    endtask

    // Drives one pixel cycle; afterwards exp_rgb is the expectation for the pixel one cycle earlier.
    task automatic drive_cycle(input int x, input int y, input bit vid, input bit fs,
                               input bit win, input logic [11:0] grb);
        int          dx, dy;
        bit          inw;
        logic [11:0] e;
        pix_x = x[9:0]; pix_y = y[9:0]; video_on = vid;
        frame_start = fs; game_win = win; game_rgb = grb;
        dx  = x - 192;
        dy  = y - 112;
        inw = (dx >= 0) && (dx < 256) && (dy >= 0) && (dy < 256);
        exp_addr = inw ? 16'(dy * 256 + dx) : 16'h0000;
        #1 obs_addr = rom_addr;
        if (fs) begin
            if (!m_show && win) begin m_show = 1'b1; m_n = 0; end
            else if (m_show && !win) m_show = 1'b0;
            else if (m_show) m_n++;
        end
        if (!vid)                              e = 12'h000;
        else if (!m_show)                      e = grb;
        else if (((m_n / c_bf) % 2) != 0)      e = c_bg;
        else if (inw && rom[exp_addr] != c_key) e = rom[exp_addr];
        else                                   e = c_bg;
        exp_ov = m_show;
        @(posedge clk); #1;
        exp_rgb = m_prev;
        m_prev  = e;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pix_x = '0; pix_y = '0; video_on = 1'b0;
        frame_start = 1'b0; game_win = 1'b0; game_rgb = '0;
        model_reset();
        @(posedge clk); #1;
        total += 2;
        if (rgb_out !== 12'h000)   begin bad++; $display("FAIL reset_rgb: got %h want 000", rgb_out); end
        if (overlay_active !== 1'b0) begin bad++; $display("FAIL reset_ov: got %b want 0", overlay_active); end
        rst = 1'b0;
    endtask

    task automatic test_addr_map();
        int          xs[4] = '{192, 447, 191, 300};
        int          ys[4] = '{112, 367, 112, 200};
        logic [15:0] ea[4] = '{16'h0000, 16'hFFFF, 16'h0000, 16'h586C};
        for (int i = 0; i < 4; i++) begin
            drive_cycle(xs[i], ys[i], 1'b1, 1'b0, 1'b0, 12'h000);
            total++;
            if (obs_addr !== ea[i]) begin
                bad++; $display("FAIL addr_map[%0d]: got %h want %h", i, obs_addr, ea[i]);
            end
        end
    endtask

    task automatic test_latency();
        drive_cycle(100, 100, 1'b1, 1'b0, 1'b0, 12'hABC);
        drive_cycle(101, 100, 1'b1, 1'b0, 1'b0, 12'h123);
        total++;
        if (rgb_out !== 12'hABC) begin bad++; $display("FAIL latency_pass: got %h want abc", rgb_out); end
        drive_cycle(5, 5, 1'b0, 1'b0, 1'b0, 12'hFFF);
        drive_cycle(6, 5, 1'b1, 1'b0, 1'b0, 12'h111);
        total++;
        if (rgb_out !== 12'h000) begin bad++; $display("FAIL latency_blank: got %h want 000", rgb_out); end
    endtask

    task automatic test_entry();
        drive_cycle(50, 50, 1'b1, 1'b0, 1'b1, 12'h321);
        drive_cycle(300, 200, 1'b1, 1'b0, 1'b1, 12'h456);
        drive_cycle(301, 200, 1'b1, 1'b0, 1'b1, 12'h789);
        total += 2;
        if (rgb_out !== 12'h456) begin bad++; $display("FAIL entry_wait_rgb: got %h want 456", rgb_out); end
        if (overlay_active !== 1'b0) begin bad++; $display("FAIL entry_wait_ov: got %b want 0", overlay_active); end
        drive_cycle(0, 0, 1'b1, 1'b1, 1'b1, 12'h111);
        total++;
        if (overlay_active !== 1'b1) begin bad++; $display("FAIL entry_ov: got %b want 1", overlay_active); end
        drive_cycle(300, 200, 1'b1, 1'b0, 1'b1, 12'h222);
        drive_cycle(10, 10, 1'b1, 1'b0, 1'b1, 12'h333);
        total++;
        if (rgb_out !== 12'h123) begin bad++; $display("FAIL entry_img: got %h want 123", rgb_out); end
        drive_cycle(20, 20, 1'b1, 1'b0, 1'b1, 12'h444);
        total++;
        if (rgb_out !== c_bg) begin bad++; $display("FAIL entry_bg: got %h want %h", rgb_out, c_bg); end
    endtask

    task automatic test_color_key();
        rom[16'h2608] = 12'hF0F;
        rom[16'h2609] = 12'hF0E;
        drive_cycle(200, 150, 1'b1, 1'b0, 1'b1, 12'h000);
        drive_cycle(201, 150, 1'b1, 1'b0, 1'b1, 12'h000);
        total++;
        if (rgb_out !== c_bg) begin bad++; $display("FAIL key_transparent: got %h want %h", rgb_out, c_bg); end
        drive_cycle(202, 150, 1'b1, 1'b0, 1'b1, 12'h000);
        total++;
        if (rgb_out !== 12'hF0E) begin bad++; $display("FAIL key_near: got %h want f0e", rgb_out); end
    endtask

    task automatic test_blink();
        bit vis_tab[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [11:0] want;
        drive_cycle(0, 0, 1'b1, 1'b1, 1'b0, 12'h000);
        for (int f = 0; f < 5; f++) begin
            drive_cycle(0, 0, 1'b1, 1'b1, 1'b1, 12'h0F0);
            drive_cycle(300, 200, 1'b1, 1'b0, 1'b1, 12'h0F1);
            drive_cycle(10, 10, 1'b1, 1'b0, 1'b1, 12'h0F2);
            want = vis_tab[f] ? 12'h123 : c_bg;
            total += 2;
            if (rgb_out !== want) begin bad++; $display("FAIL blink_img[%0d]: got %h want %h", f, rgb_out, want); end
            if (overlay_active !== 1'b1) begin bad++; $display("FAIL blink_ov[%0d]: got %b want 1", f, overlay_active); end
            drive_cycle(11, 10, 1'b1, 1'b0, 1'b1, 12'h0F3);
            total++;
            if (rgb_out !== c_bg) begin bad++; $display("FAIL blink_bg[%0d]: got %h want %h", f, rgb_out, c_bg); end
        end
        drive_cycle(12, 10, 1'b1, 1'b0, 1'b0, 12'hAAA);
        total++;
        if (overlay_active !== 1'b1) begin bad++; $display("FAIL blink_drop_hold: got %b want 1", overlay_active); end
        drive_cycle(0, 0, 1'b1, 1'b1, 1'b0, 12'hBBB);
        drive_cycle(300, 200, 1'b1, 1'b0, 1'b0, 12'hCCC);
        total += 2;
        if (overlay_active !== 1'b0) begin bad++; $display("FAIL blink_exit_ov: got %b want 0", overlay_active); end
        if (rgb_out !== 12'hBBB) begin bad++; $display("FAIL blink_exit_rgb: got %h want bbb", rgb_out); end
    endtask

    task automatic test_random();
        bit win = 1'b0;
        bit fs, vid;
        int x, y;
        for (int i = 0; i < 3000; i++) begin
            fs  = ($urandom_range(0, 39) == 0);
            vid = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 99) == 0) win = ~win;
            if ($urandom_range(0, 1) == 0) begin
                x = $urandom_range(180, 460); y = $urandom_range(100, 380);
            end else begin
                x = $urandom_range(0, 700);   y = $urandom_range(0, 520);
            end
            drive_cycle(x, y, vid, fs, win, 12'($urandom));
            total += 2;
            if (rgb_out !== exp_rgb) begin bad++; $display("FAIL rand_rgb[%0d]: got %h want %h", i, rgb_out, exp_rgb); end
            if (overlay_active !== exp_ov) begin bad++; $display("FAIL rand_ov[%0d]: got %b want %b", i, overlay_active, exp_ov); end
            if (vid) begin
                total++;
                if (obs_addr !== exp_addr) begin bad++; $display("FAIL rand_addr[%0d]: got %h want %h", i, obs_addr, exp_addr); end
            end
        end
    endtask

    task automatic test_reset_mid_show();
        drive_cycle(0, 0, 1'b1, 1'b1, 1'b1, 12'h100);
        drive_cycle(300, 200, 1'b1, 1'b0, 1'b1, 12'h101);
        drive_cycle(301, 200, 1'b1, 1'b0, 1'b1, 12'h102);
        #2 rst = 1'b1;
        #1;
        total += 2;
        if (rgb_out !== 12'h000)     begin bad++; $display("FAIL rst_mid_rgb: got %h want 000", rgb_out); end
        if (overlay_active !== 1'b0) begin bad++; $display("FAIL rst_mid_ov: got %b want 0", overlay_active); end
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        drive_cycle(100, 100, 1'b1, 1'b0, 1'b1, 12'hDEF);
        drive_cycle(101, 100, 1'b1, 1'b0, 1'b1, 12'h000);
        total += 2;
        if (rgb_out !== 12'hDEF)     begin bad++; $display("FAIL rst_pass: got %h want def", rgb_out); end
        if (overlay_active !== 1'b0) begin bad++; $display("FAIL rst_idle_ov: got %b want 0", overlay_active); end
        drive_cycle(0, 0, 1'b1, 1'b1, 1'b1, 12'h001);
        total++;
        if (overlay_active !== 1'b1) begin bad++; $display("FAIL rst_reentry_ov: got %b want 1", overlay_active); end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++)
            rom[a] = ($urandom_range(0, 7) == 0) ? c_key : 12'($urandom);
        rom[16'h586C] = 12'h123;
        test_reset();
        test_addr_map();
        test_latency();
        test_entry();
        test_color_key();
        test_blink();
        test_random();
        test_reset_mid_show();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
